// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin, wormhole-locking output arbiter for one router output port
module noc_output_arbiter #(
    parameter int N_PORTS   = 5,
    parameter int SEL_W     = $clog2(N_PORTS),
    parameter int PKT_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     empty_i,
    input  logic [2*N_PORTS-1:0]   flit_type_i,
    input  logic                   on_off_i,
    output logic [N_PORTS-1:0]     read_o,
    output logic                   valid_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic [N_PORTS-1:0]     grant_o,
    output logic                   locked_o,
    output logic                   err_o,
    output logic [PKT_CNT_W-1:0]   pkt_cnt_o
);
    localparam logic [1:0] FT_HEAD     = 2'b00;
    localparam logic [1:0] FT_BODY     = 2'b01;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     owner;
    logic [SEL_W-1:0]     rr_ptr;
    logic                 err;
    logic [PKT_CNT_W-1:0] pkt_cnt;

    logic [N_PORTS-1:0]   eligible;
    logic [N_PORTS-1:0]   bad;
    logic                 found;
    logic [SEL_W-1:0]     winner;
    logic [1:0]           winner_type;
    logic [1:0]           owner_type;
    logic                 idle_xfer;
    logic                 lock_xfer;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = !empty_i[i] && (flit_type_i[2*i +: 2] == FT_HEAD ||
                                          flit_type_i[2*i +: 2] == FT_HEADTAIL);
            bad[i]      = !empty_i[i] && (flit_type_i[2*i +: 2] == FT_BODY ||
                                          flit_type_i[2*i +: 2] == FT_TAIL);
        end
    end

    // Scan starts just after the last winner and wraps explicitly at N_PORTS.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!found && eligible[SEL_W'(idx)]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        winner_type = FT_HEAD;
        owner_type  = FT_HEAD;
        for (int i = 0; i < N_PORTS; i++) begin
            if (SEL_W'(i) == winner) begin
                winner_type = flit_type_i[2*i +: 2];
            end
            if (SEL_W'(i) == owner) begin
                owner_type = flit_type_i[2*i +: 2];
            end
        end
    end

    assign idle_xfer = (state == S_IDLE)   && !rst && on_off_i && found;
    assign lock_xfer = (state == S_LOCKED) && !rst && on_off_i && !empty_i[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (idle_xfer && winner_type == FT_HEAD) begin
                    state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (lock_xfer && owner_type == FT_TAIL) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_o  = '0;
        grant_o = '0;
        sel_o   = rr_ptr;
        for (int i = 0; i < N_PORTS; i++) begin
            if (state == S_LOCKED) begin
                read_o[i]  = lock_xfer && (SEL_W'(i) == owner);
                grant_o[i] = !rst && (SEL_W'(i) == owner);
            end else begin
                read_o[i]  = idle_xfer && (SEL_W'(i) == winner);
                grant_o[i] = read_o[i];
            end
        end
        if (state == S_LOCKED) begin
            sel_o = owner;
        end else if (idle_xfer) begin
            sel_o = winner;
        end
        valid_o = |read_o;
    end

    // rr_ptr keeps the owner after a packet, so the owner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= '0;
            rr_ptr  <= SEL_W'(N_PORTS - 1);
            err     <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (idle_xfer) begin
                rr_ptr <= winner;
                if (winner_type == FT_HEAD) begin
                    owner <= winner;
                end
            end
            if ((state == S_IDLE && |bad) ||
                (lock_xfer && (owner_type == FT_HEAD || owner_type == FT_HEADTAIL))) begin
                err <= 1'b1;
            end
            if ((idle_xfer && winner_type == FT_HEADTAIL) ||
                (lock_xfer && owner_type == FT_TAIL)) begin
                pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
            end
        end
    end

    assign locked_o  = (state == S_LOCKED);
    assign err_o     = err;
    assign pkt_cnt_o = pkt_cnt;
endmodule
